// File: rtl/pmp_cmd_rx_if.sv
// PMP write bus from the PIC: 8-bit data, active-high strobe and active-low write qualifier.
// The PIC drives the master side; the FPGA receiver samples the slave side asynchronously.
interface pmp_cmd_rx_if;
  logic [7:0] pmp_d;
  logic       pmp_enb;
  logic       pmp_wrn;

  modport master (output pmp_d, output pmp_enb, output pmp_wrn);
  modport slave  (input  pmp_d, input  pmp_enb, input  pmp_wrn);
endinterface

// File: rtl/pmp_cmd_rx.sv
// PMP slave write receiver: decodes ADDR/DATA frames from the PIC into a control-register file.
// Define PMP_RX_CHECKSUM_EN for 3-byte frames whose trailing CHK byte must equal ADDR^DATA.
module pmp_cmd_rx #(
  parameter int         NREGS     = 8,
  parameter int         AW        = 3,
  parameter logic [7:0] RESET_VAL = 8'h00,
  parameter int         TIMEOUT   = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  pmp_cmd_rx_if.slave        pmp,
  output logic [NREGS*8-1:0] reg_q,
  output logic               wr_stb,
  output logic [AW-1:0]      wr_addr,
  output logic [7:0]         wr_data,
  output logic               frame_err,
  output logic [7:0]         err_cnt
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

`ifdef PMP_RX_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    WAIT_CHK  = 2'd2
  } state_t;
`else
  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_DATA = 1'b1
  } state_t;
`endif

  logic [7:0] d_s1_reg, d_s2_reg;
  logic       enb_s1_reg, enb_s2_reg;
  logic       wrn_s1_reg, wrn_s2_reg;
  logic       wstb_d_reg;
  logic       armed_reg;
  logic       wstb;
  logic       byte_ev;
  logic [7:0] byte_val;

  state_t     state_reg, state_next;
  logic [6:0] addr_reg, addr_next;
  logic [7:0] data_reg, data_next;
  logic [CW-1:0] to_cnt_reg, to_cnt_next;
  logic       timeout_hit;

  logic       commit_try;
  logic       proto_err;
  logic [7:0] commit_data;
  logic       in_range;
  logic       commit;
  logic       err_pulse;

  logic          wr_stb_reg;
  logic [AW-1:0] wr_addr_reg;
  logic [7:0]    wr_data_reg;
  logic          frame_err_reg;
  logic [7:0]    err_cnt_reg;

  // Two-flop synchronisers on every PMP pin, plus one delay stage on the write strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_s1_reg   <= 8'h00;
      d_s2_reg   <= 8'h00;
      enb_s1_reg <= 1'b0;
      enb_s2_reg <= 1'b0;
      wrn_s1_reg <= 1'b0;
      wrn_s2_reg <= 1'b0;
      wstb_d_reg <= 1'b0;
      armed_reg  <= 1'b0;
    end else begin
      d_s1_reg   <= pmp.pmp_d;
      d_s2_reg   <= d_s1_reg;
      enb_s1_reg <= pmp.pmp_enb;
      enb_s2_reg <= enb_s1_reg;
      wrn_s1_reg <= pmp.pmp_wrn;
      wrn_s2_reg <= wrn_s1_reg;
      wstb_d_reg <= wstb;
      if (wstb)
        armed_reg <= 1'b1;
    end
  end

  assign wstb     = enb_s2_reg & ~wrn_s2_reg;
  assign byte_ev  = wstb_d_reg & ~wstb & armed_reg;
  assign byte_val = d_s2_reg;

  generate
    if (TIMEOUT != 0) begin : g_timeout
      assign timeout_hit = (state_reg != IDLE) && (to_cnt_reg == CW'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    to_cnt_next = to_cnt_reg + 1'b1;
    if (state_reg == IDLE || byte_ev)
      to_cnt_next = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      addr_reg   <= 7'd0;
      data_reg   <= 8'h00;
      to_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      data_reg   <= data_next;
      to_cnt_reg <= to_cnt_next;
    end
  end

  // Timeout takes priority: a byte landing on the expiry cycle is dropped.
  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    data_next   = data_reg;
    commit_try  = 1'b0;
    proto_err   = 1'b0;
    commit_data = data_reg;
    if (timeout_hit) begin
      state_next = IDLE;
      proto_err  = 1'b1;
    end else if (byte_ev) begin
      case (state_reg)
        IDLE: begin
          if (byte_val[7]) begin
            addr_next  = byte_val[6:0];
            state_next = WAIT_DATA;
          end else begin
            proto_err = 1'b1;
          end
        end
        WAIT_DATA: begin
          data_next = byte_val;
`ifdef PMP_RX_CHECKSUM_EN
          state_next = WAIT_CHK;
`else
          commit_try  = 1'b1;
          commit_data = byte_val;
          state_next  = IDLE;
`endif
        end
`ifdef PMP_RX_CHECKSUM_EN
        WAIT_CHK: begin
          state_next = IDLE;
          if (byte_val == ({1'b1, addr_reg} ^ data_reg))
            commit_try = 1'b1;
          else
            proto_err = 1'b1;
        end
`endif
        default: state_next = IDLE;
      endcase
    end
  end

  assign in_range  = int'(addr_reg) < NREGS;
  assign commit    = commit_try & in_range;
  assign err_pulse = proto_err | (commit_try & ~in_range);

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi = gi + 1) begin : g_regs
      logic [7:0] r_reg;
      always_ff @(posedge clk) begin
        if (!rst_n)
          r_reg <= RESET_VAL;
        else if (commit && (int'(addr_reg) == gi))
          r_reg <= commit_data;
      end
      assign reg_q[8*gi +: 8] = r_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_stb_reg    <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= 8'h00;
      frame_err_reg <= 1'b0;
      err_cnt_reg   <= 8'h00;
    end else begin
      wr_stb_reg    <= commit;
      frame_err_reg <= err_pulse;
      if (commit) begin
        wr_addr_reg <= addr_reg[AW-1:0];
        wr_data_reg <= commit_data;
      end
      if (err_pulse && err_cnt_reg != 8'hFF)
        err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign wr_stb    = wr_stb_reg;
  assign wr_addr   = wr_addr_reg;
  assign wr_data   = wr_data_reg;
  assign frame_err = frame_err_reg;
  assign err_cnt   = err_cnt_reg;

endmodule
